// File: rtl/paddle_hit_estimator_pkg.sv
// Shared types and defaults for the paddle hit estimator.
// Holds the hit FSM encoding, screen limits and a wrap-free 11-bit distance helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HIT_HOLD = 2'd1,
        COOLDOWN = 2'd2
    } hit_state_t;

    localparam int CAM_W = 320;
    localparam int CAM_H = 240;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    localparam int DEF_HIST_DEPTH      = 4;
    localparam int DEF_SPEED_SHIFT     = 2;
    localparam int DEF_SPEED_MAX       = 8;
    localparam int DEF_HIT_X_WIN       = 16;
    localparam int DEF_HIT_Y_WIN       = 24;
    localparam int DEF_COLL_HOLD       = 2;
    localparam int DEF_COOLDOWN_FRAMES = 6;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/paddle_hit_estimator_if.sv
// Tracking/ball inputs and collision/speed outputs between the video path and the game controller.
// master drives the tracking side, slave is the estimator.
interface paddle_hit_estimator_if;
    logic       upscale;
    logic       frame_done;
    logic       paddle_valid;
    logic [9:0] paddle_x;
    logic [9:0] paddle_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       is_ball_moving_right;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic       paddle_lost;
    logic [7:0] hit_count;

    modport master (
        output upscale, frame_done, paddle_valid, paddle_x, paddle_y,
        output ball_x, ball_y, is_ball_moving_right,
        input  collision_detected, estimated_speed, paddle_lost, hit_count
    );

    modport slave (
        input  upscale, frame_done, paddle_valid, paddle_x, paddle_y,
        input  ball_x, ball_y, is_ball_moving_right,
        output collision_detected, estimated_speed, paddle_lost, hit_count
    );
endinterface

// File: rtl/paddle_hit_estimator_history.sv
// Per-frame paddle-Y history; raw speed is |newest - oldest| >> SPEED_SHIFT clamped to [1, SPEED_MAX].
// raw_speed is combinational on the registered history (updated on each frame_done).
module paddle_history
    import pong_pkg::*;
#(
    parameter int HIST_DEPTH  = DEF_HIST_DEPTH,
    parameter int SPEED_SHIFT = DEF_SPEED_SHIFT,
    parameter int SPEED_MAX   = DEF_SPEED_MAX
) (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic        frame_done,
    input  logic        paddle_valid,
    input  logic [10:0] py_in,
    output logic [9:0]  raw_speed
);
    localparam int FW = $clog2(HIST_DEPTH + 1);

    logic [10:0]   hist_q [HIST_DEPTH];
    logic [10:0]   hist_d [HIST_DEPTH];
    logic [FW-1:0] fill_q, fill_d;
    logic [10:0]   disp;
    logic [10:0]   shifted;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (frame_done) begin
            if (paddle_valid) begin
                hist_d[0] = py_in;
                for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
                if (fill_q != FW'(HIST_DEPTH)) fill_d = fill_q + 1'b1;
            end else begin
                for (int i = 0; i < HIST_DEPTH; i++) hist_d[i] = '0;
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            hist_q <= '{default: '0};
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Speed is only trusted once the window spans HIST_DEPTH frames.
    always_comb begin
        disp    = abs_diff(hist_q[0], hist_q[HIST_DEPTH-1]);
        shifted = disp >> SPEED_SHIFT;
        if (fill_q != FW'(HIST_DEPTH) || shifted == '0)
            raw_speed = 10'd1;
        else if (shifted > 11'(SPEED_MAX))
            raw_speed = 10'(SPEED_MAX);
        else
            raw_speed = shifted[9:0];
    end

endmodule

// File: rtl/paddle_hit_estimator.sv
// Paddle hit estimator: scales the paddle centroid, detects ball contact, holds a clean collision pulse.
// Optional SPEED_FILTER_EN macro averages successive speed estimates instead of using the raw value.
module paddle_hit_estimator
    import pong_pkg::*;
#(
    parameter int HIST_DEPTH      = DEF_HIST_DEPTH,
    parameter int SPEED_SHIFT     = DEF_SPEED_SHIFT,
    parameter int SPEED_MAX       = DEF_SPEED_MAX,
    parameter int HIT_X_WIN       = DEF_HIT_X_WIN,
    parameter int HIT_Y_WIN       = DEF_HIT_Y_WIN,
    parameter int COLL_HOLD       = DEF_COLL_HOLD,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input logic                     clk_25MHZ,
    input logic                     reset,
    paddle_hit_estimator_if.slave   bus
);
    localparam int HW = $clog2(COLL_HOLD + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    hit_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [10:0]   px_q, px_d, py_q, py_d;
    logic          lost_q, lost_d;
    logic          pend_q, pend_d;
    logic [9:0]    speed_q, speed_d;
    logic [7:0]    hit_cnt_q, hit_cnt_d;
    logic [10:0]   px_scaled, py_scaled;
    logic [9:0]    raw_speed;
    logic          hit_cond;
    logic          in_hold;
    logic          hit_take;
`ifdef SPEED_FILTER_EN
    logic          flush_q, flush_d;
    logic [10:0]   filt;
`endif

    assign px_scaled = bus.upscale ? {bus.paddle_x, 1'b0} : {1'b0, bus.paddle_x};
    assign py_scaled = bus.upscale ? {bus.paddle_y, 1'b0} : {1'b0, bus.paddle_y};

    // Compares against the latched centroid, so a same-cycle frame_done sees the previous frame.
    assign hit_cond = bus.is_ball_moving_right && !lost_q
                   && (abs_diff({1'b0, bus.ball_x}, px_q) <= 11'(HIT_X_WIN))
                   && (abs_diff({1'b0, bus.ball_y}, py_q) <= 11'(HIT_Y_WIN));

    paddle_history #(
        .HIST_DEPTH (HIST_DEPTH),
        .SPEED_SHIFT(SPEED_SHIFT),
        .SPEED_MAX  (SPEED_MAX)
    ) u_history (
        .clk_25MHZ   (clk_25MHZ),
        .reset       (reset),
        .frame_done  (bus.frame_done),
        .paddle_valid(bus.paddle_valid),
        .py_in       (py_scaled),
        .raw_speed   (raw_speed)
    );

    // FSM: state register
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state_q <= ARMED;
            hold_q  <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
        case (state_q)
            ARMED: begin
                if (hit_cond) begin
                    state_d = HIT_HOLD;
                    hold_d  = HW'(COLL_HOLD);
                end
            end
            HIT_HOLD: begin
                if (hold_q == HW'(1)) begin
                    state_d = COOLDOWN;
                    cool_d  = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            COOLDOWN: begin
                if (bus.frame_done) begin
                    if (cool_q == CW'(COOLDOWN_FRAMES - 1)) state_d = ARMED;
                    else                                     cool_d  = cool_q + 1'b1;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_hold  = (state_q == HIT_HOLD);
        hit_take = (state_q == ARMED) && hit_cond;
    end

    // Datapath next values
    always_comb begin
        px_d      = px_q;
        py_d      = py_q;
        lost_d    = lost_q;
        hit_cnt_d = hit_take ? hit_cnt_q + 8'd1 : hit_cnt_q;
        pend_d    = bus.frame_done && !in_hold;
        speed_d   = speed_q;
        if (bus.frame_done) begin
            lost_d = !bus.paddle_valid;
            if (bus.paddle_valid) begin
                px_d = px_scaled;
                py_d = py_scaled;
            end
        end
`ifdef SPEED_FILTER_EN
        flush_d = bus.frame_done && !bus.paddle_valid;
        filt    = ({1'b0, speed_q} + {1'b0, raw_speed} + 11'd1) >> 1;
        if (pend_q && !in_hold) speed_d = flush_q ? 10'd1 : filt[9:0];
`else
        if (pend_q && !in_hold) speed_d = raw_speed;
`endif
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            px_q      <= '0;
            py_q      <= '0;
            lost_q    <= 1'b1;
            pend_q    <= 1'b0;
            speed_q   <= 10'd1;
            hit_cnt_q <= '0;
`ifdef SPEED_FILTER_EN
            flush_q   <= 1'b0;
`endif
        end else begin
            px_q      <= px_d;
            py_q      <= py_d;
            lost_q    <= lost_d;
            pend_q    <= pend_d;
            speed_q   <= speed_d;
            hit_cnt_q <= hit_cnt_d;
`ifdef SPEED_FILTER_EN
            flush_q   <= flush_d;
`endif
        end
    end

    assign bus.collision_detected = in_hold;
    assign bus.estimated_speed    = speed_q;
    assign bus.paddle_lost        = lost_q;
    assign bus.hit_count          = hit_cnt_q;

endmodule
